ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 8, SHALL set the RAM address and data width.
REQ-002 Parameter TIMEOUT, default 8, SHALL set the maximum number of WAIT cycles for a read response.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port req_valid, input, 2 bits: per-requester transaction request.
REQ-006 Port req_ready, output, 2 bits: per-requester accept strobe.
REQ-007 Port req_wr, input, 2 bits: per-requester operation select, 1=write, 0=read.
REQ-008 Port req_addr, input, 2*ADDR_SIZE bits: requester i address in bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-009 Port req_wdata, input, 2*ADDR_SIZE bits: per-requester write data, packed the same way as req_addr.
REQ-010 Port rsp_valid, output, 2 bits: one-cycle completion pulse to the owning requester.
REQ-011 Port rsp_err, output, 1 bit: read timeout flag, qualified by rsp_valid.
REQ-012 Port rsp_rdata, output, ADDR_SIZE bits: read data, qualified by rsp_valid.
REQ-013 Port ram_din, output, ADDR_SIZE+2 bits: RAM command word, opcode in bits [ADDR_SIZE+1:ADDR_SIZE].
REQ-014 Port ram_rx_valid, output, 1 bit: RAM command strobe.
REQ-015 Port ram_dout, input, ADDR_SIZE bits: RAM read data.
REQ-016 Port ram_tx_valid, input, 1 bit: RAM read data valid.

Function
REQ-017 Opcodes SHALL be: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-018 The FSM SHALL have the states IDLE, ADDR, DATA, WAIT and RESP.
REQ-019 In IDLE with any req_valid set, the grant SHALL be round-robin: the requester not granted last wins when both request; at reset, requester 0 has priority.
REQ-020 req_ready SHALL be combinational, high only for the granted requester and only in IDLE.
REQ-021 On acceptance (valid&ready), the block SHALL capture the owner, operation, address and wdata, update the round-robin pointer, and go to ADDR.
REQ-022 In ADDR: ram_rx_valid=1, ram_din={00 or 10, addr}; next state SHALL be DATA.
REQ-023 In DATA: ram_rx_valid=1, ram_din={01, wdata} for a write or {11, 0} for a read; next state SHALL be RESP for a write and WAIT for a read.
REQ-024 ram_rx_valid SHALL be 0 in IDLE, WAIT and RESP.
REQ-025 In WAIT, sampling ram_tx_valid=1 SHALL capture ram_dout into rsp_rdata, clear rsp_err and go to RESP.
REQ-026 If TIMEOUT WAIT cycles elapse without ram_tx_valid, the block SHALL set rsp_err=1 and rsp_rdata=0 and go to RESP.
REQ-027 The WAIT cycle counter SHALL be cleared on entry to WAIT.
REQ-028 In RESP, rsp_valid[owner]=1 for exactly one cycle, then IDLE; no new request SHALL be accepted in RESP.
REQ-029 Write latency SHALL be: acceptance edge, then ADDR, DATA, then rsp_valid in the 3rd cycle after acceptance; a write SHALL report rsp_err=0.
REQ-030 Read latency with a RAM responding in one cycle SHALL be rsp_valid in the 4th cycle after acceptance.
REQ-031 Requests arriving while the block is busy SHALL be held by the requester; none SHALL be dropped or reordered per requester.
REQ-032 req_valid deasserting before acceptance SHALL NOT be an error and SHALL NOT change any state.

Reset
REQ-033 rst_n low SHALL asynchronously force: state=IDLE, round-robin pointer to requester 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_rx_valid=0, ram_din=0, counter=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no rsp_valid pulse.
REQ-035 The first grant after reset SHALL go to requester 0 if both requesters are valid.

Structure
REQ-036 Package ram_ctrl_pkg SHALL hold the opcode constants and the FSM state enum.
REQ-037 Round-robin grant logic SHALL be a sub-module named ram_rr_arb (inputs req[1:0] and the last-grant pointer; output one-hot grant).

Verification
REQ-038 Write req0 addr 0x12 data 0xA5 -> ram_din 0x012 then 0x1A5 on consecutive cycles; rsp_valid[0] on the 3rd cycle after acceptance; rsp_err=0.
REQ-039 Read req1 addr 0x12 with a RAM model -> ram_din 0x212 then 0x300; rsp_valid[1] with rsp_rdata=0xA5 on the 4th cycle after acceptance.
REQ-040 Both requesters valid continuously for 4 transactions -> grants 0,1,0,1.
REQ-041 Read with ram_tx_valid held 0 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 8 WAIT cycles.
REQ-042 rst_n low during DATA of a write -> all outputs 0 immediately; no rsp_valid; the next grant follows REQ-035.
REQ-043 req0 valid for one cycle while the block is busy, then dropped -> no acceptance and no RAM command for req0.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - RAM command opcodes and arbiter FSM state type
package ram_ctrl_pkg;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WAIT,
      ST_RESP
   } state_e;

   function automatic logic [1:0] addr_opcode(input logic wr);
      return wr ? OP_WR_ADDR : OP_RD_ADDR;
   endfunction

   function automatic logic [1:0] data_opcode(input logic wr);
      return wr ? OP_WR_DATA : OP_RD_DATA;
   endfunction

endpackage

// File: rtl/ram_rr_arb.sv
// rtl/ram_rr_arb.sv - two-way round-robin grant, one-hot output
module ram_rr_arb (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // on contention the requester not served last wins
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter issuing address/data command pairs to a RAM
module ram_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_wr,
   input  logic [2*ADDR_SIZE-1:0] req_addr,
   input  logic [2*ADDR_SIZE-1:0] req_wdata,
   output logic [1:0]             rsp_valid,
   output logic                   rsp_err,
   output logic [ADDR_SIZE-1:0]   rsp_rdata,
   output logic [ADDR_SIZE+1:0]   ram_din,
   output logic                   ram_rx_valid,
   input  logic [ADDR_SIZE-1:0]   ram_dout,
   input  logic                   ram_tx_valid
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic                   prio_q, prio_d;
   logic                   owner_q, owner_d;
   logic                   wr_q, wr_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [ADDR_SIZE-1:0]   wdata_q, wdata_d;
   logic [ADDR_SIZE-1:0]   rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [1:0]             grant;
   logic                   accept;
   logic                   acc_idx;

   // prio_q names the requester that wins a tie; the arbiter wants the last winner
   ram_rr_arb u_rr_arb (
      .req        (req_valid),
      .last_grant (~prio_q),
      .grant      (grant)
   );

   assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign acc_idx   = req_ready[1];

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               owner_d = acc_idx;
               wr_d    = acc_idx ? req_wr[1] : req_wr[0];
               addr_d  = acc_idx ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]
                                 : req_addr[ADDR_SIZE-1:0];
               wdata_d = acc_idx ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE]
                                 : req_wdata[ADDR_SIZE-1:0];
               prio_d  = ~acc_idx;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: state_d = ST_DATA;
         ST_DATA: begin
            cnt_d   = '0;
            state_d = wr_q ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (ram_tx_valid) begin
               rdata_d = ram_dout;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ram_rx_valid = 1'b0;
      ram_din      = '0;
      rsp_valid    = 2'b00;
      case (state_q)
         ST_ADDR: begin
            ram_rx_valid = 1'b1;
            ram_din      = {addr_opcode(wr_q), addr_q};
         end
         ST_DATA: begin
            ram_rx_valid = 1'b1;
            ram_din      = {data_opcode(wr_q), wr_q ? wdata_q : {ADDR_SIZE{1'b0}}};
         end
         ST_RESP: rsp_valid = owner_q ? 2'b10 : 2'b01;
         default: ;
      endcase
   end

   assign rsp_err   = err_q;
   assign rsp_rdata = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized self-checking bench for ram_arbiter
module tb_ram_arbiter;

   localparam int AS = 8;
   localparam int TO = 8;

   typedef struct {
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
      int         delay;
      int         gap;
   } txn_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid, req_ready, req_wr, rsp_valid;
   logic [2*AS-1:0] req_addr, req_wdata;
   logic            rsp_err;
   logic [AS-1:0]   rsp_rdata, ram_dout;
   logic [AS+1:0]   ram_din;
   logic            ram_rx_valid, ram_tx_valid;

   ram_arbiter #(.ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   txn_t       q0[$];
   txn_t       q1[$];
   int         grant_log[$];
   int         n = 0;
   int         acc, resp_k, owner, prio;
   bit         have_txn;
   bit         exp_err;
   logic [7:0] exp_rdata;
   txn_t       cur, force_t;
   logic [1:0] force_v;
   int         gap_left[2];
   bit         loaded[2];
   int         acc_cnt[2];
   logic [7:0] ref_mem[256];
   logic [7:0] ram_mem[256];
   logic [7:0] ram_addr_l;
   int         hits55;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int r, input bit wr, input logic [7:0] addr,
                       input logic [7:0] data, input int delay, input int gap);
      txn_t t;
      t.wr = wr; t.addr = addr; t.data = data; t.delay = delay; t.gap = gap;
      if (r == 0) q0.push_back(t); else q1.push_back(t);
   endtask

   // one clock: drive requesters and RAM, then check outputs against the transaction model
   task automatic step();
      txn_t       t[2];
      bit         has[2];
      logic [1:0] exp_ready;
      int         k;
      @(negedge clk);
      n++;
      if (have_txn && (n - acc) > resp_k) have_txn = 0;
      for (int r = 0; r < 2; r++) begin
         has[r] = 0;
         t[r].wr = 0; t[r].addr = 0; t[r].data = 0; t[r].delay = 0; t[r].gap = 0;
         if (force_v[r]) begin
            t[r] = force_t;
            has[r] = 1;
         end else if ((r == 0 ? q0.size() : q1.size()) > 0) begin
            t[r] = (r == 0) ? q0[0] : q1[0];
            if (!loaded[r]) begin gap_left[r] = t[r].gap; loaded[r] = 1; end
            if (gap_left[r] > 0) gap_left[r]--; else has[r] = 1;
         end
      end
      req_valid = {has[1], has[0]};
      req_wr    = {t[1].wr, t[0].wr};
      req_addr  = {t[1].addr, t[0].addr};
      req_wdata = {t[1].data, t[0].data};
      ram_tx_valid = 1'b0;
      ram_dout     = 8'($urandom);
      if (have_txn && !cur.wr && cur.delay < TO && (n - acc) == 3 + cur.delay) begin
         ram_tx_valid = 1'b1;
         ram_dout     = ram_mem[ram_addr_l];
      end
      #1;
      exp_ready = 2'b00;
      if (!have_txn) begin
         if (has[0] && has[1]) exp_ready = (prio == 0) ? 2'b01 : 2'b10;
         else                  exp_ready = {has[1], has[0]};
      end
      chk("req_ready", req_ready, exp_ready);
      if (have_txn) begin
         k = n - acc;
         chk("ram_rx_valid", ram_rx_valid, (k == 1 || k == 2));
         if (k == 1) chk("ram_din_addr", ram_din, {cur.wr ? 2'b00 : 2'b10, cur.addr});
         if (k == 2) chk("ram_din_data", ram_din, cur.wr ? {2'b01, cur.data} : {2'b11, 8'h00});
         chk("rsp_valid", rsp_valid, (k == resp_k) ? (owner ? 2'b10 : 2'b01) : 2'b00);
         if (k == resp_k) begin
            chk("rsp_err", rsp_err, exp_err);
            if (!cur.wr) chk("rsp_rdata", rsp_rdata, exp_rdata);
         end
      end else begin
         chk("ram_rx_valid_idle", ram_rx_valid, 1'b0);
         chk("rsp_valid_idle", rsp_valid, 2'b00);
      end
      if (ram_rx_valid === 1'b1) begin
         case (ram_din[9:8])
            2'b00, 2'b10: begin
               ram_addr_l = ram_din[7:0];
               if (ram_din[7:0] == 8'h55) hits55++;
            end
            2'b01: ram_mem[ram_addr_l] = ram_din[7:0];
            default: ;
         endcase
      end
      if ((req_valid & req_ready) != 2'b00) begin
         owner = (req_ready[1] & req_valid[1]) ? 1 : 0;
         cur = t[owner];
         acc = n;
         have_txn = 1;
         prio = 1 - owner;
         acc_cnt[owner]++;
         grant_log.push_back(owner);
         if (cur.wr) begin
            resp_k = 3; exp_err = 0;
            ref_mem[cur.addr] = cur.data;
         end else if (cur.delay < TO) begin
            resp_k = 4 + cur.delay; exp_err = 0;
            exp_rdata = ref_mem[cur.addr];
         end else begin
            resp_k = 3 + TO; exp_err = 1; exp_rdata = 8'h00;
         end
         if (!force_v[owner]) begin
            if (owner == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            loaded[owner] = 0;
         end
      end
   endtask

   task automatic drain(input string tag, input int max_cycles);
      int c = 0;
      while ((q0.size() > 0 || q1.size() > 0 || have_txn) && c < max_cycles) begin
         step();
         c++;
      end
      chk(tag, (c < max_cycles), 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 2'b00);
      chk({tag, "_rsp_valid"}, rsp_valid, 2'b00);
      chk({tag, "_rsp_err"}, rsp_err, 1'b0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
      chk({tag, "_ram_rx_valid"}, ram_rx_valid, 1'b0);
      chk({tag, "_ram_din"}, ram_din, 10'h000);
   endtask

   initial begin
      int base, c, saved0;
      logic [7:0] v;
      rst_n = 1'b0;
      req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
      ram_tx_valid = 1'b0; ram_dout = '0;
      force_v = 2'b00; have_txn = 0; prio = 0; hits55 = 0;
      ram_addr_l = 8'h00;
      for (int r = 0; r < 2; r++) begin gap_left[r] = 0; loaded[r] = 0; acc_cnt[r] = 0; end
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         ref_mem[i] = v;
         ram_mem[i] = v;
      end

      step();
      step();
      check_outputs_zero("reset");
      rst_n = 1'b1;

      // single write then read-back of the same location
      push(0, 1, 8'h12, 8'hA5, 0, 0);
      drain("drain_write", 50);
      push(1, 0, 8'h12, 8'h00, 0, 0);
      drain("drain_read", 50);

      // both requesters contending: strict alternation
      base = grant_log.size();
      push(0, 1, 8'h01, 8'h11, 0, 0);
      push(0, 0, 8'h01, 8'h00, 1, 0);
      push(1, 1, 8'h02, 8'h22, 0, 0);
      push(1, 0, 8'h02, 8'h00, 2, 0);
      drain("drain_rr", 100);
      chk("rr_grant0", grant_log[base],     0);
      chk("rr_grant1", grant_log[base + 1], 1);
      chk("rr_grant2", grant_log[base + 2], 0);
      chk("rr_grant3", grant_log[base + 3], 1);

      // read with a silent RAM times out
      push(0, 0, 8'h12, 8'h00, 2 * TO, 0);
      drain("drain_timeout", 50);

      // a pulse on req0 while busy must leave no trace
      saved0 = acc_cnt[0];
      hits55 = 0;
      push(1, 1, 8'h07, 8'h99, 0, 0);
      c = 0;
      while (!(have_txn && (n - acc) == 1) && c < 50) begin step(); c++; end
      force_t.wr = 1; force_t.addr = 8'h55; force_t.data = 8'h66;
      force_t.delay = 0; force_t.gap = 0;
      force_v = 2'b01;
      step();
      force_v = 2'b00;
      drain("drain_drop", 100);
      chk("drop_no_accept", acc_cnt[0], saved0);
      chk("drop_no_ram_cmd", hits55, 0);

      // reset in the DATA cycle of a write
      push(0, 1, 8'hC3, 8'h77, 0, 0);
      c = 0;
      while (!(have_txn && (n - acc) == 2) && c < 50) begin step(); c++; end
      chk("reach_data", (have_txn && (n - acc) == 2), 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      have_txn = 0;
      prio = 0;
      step();
      step();
      rst_n = 1'b1;
      base = grant_log.size();
      push(1, 0, 8'h05, 8'h00, 0, 0);
      push(0, 0, 8'h12, 8'h00, 0, 0);
      drain("drain_post_reset", 100);
      chk("post_reset_grant", grant_log[base], 0);

      // randomized traffic with gaps and varied RAM latency
      for (int i = 0; i < 40; i++) begin
         push($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
              8'($urandom), ($urandom_range(0, 4) == 0) ? 2 * TO : $urandom_range(0, TO - 1),
              $urandom_range(0, 3));
      end
      drain("drain_random", 5000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
